wb_trace_buf: RTL
=================

# wb_trace_buf

Hardware trace capture buffer that consumes the CPU's diagnostic write-back and store ports (wb_regwrite/wb_regdata, mem_memwrite/mem_memdata) and records each event into an on-chip FIFO with a cycle stamp. A host or bench drains the FIFO through a valid/ready stream. It sits beside the cpu instance as the receiving end of the diagnostic interface, replacing $monitor-style observation in synthesizable builds.

## Interface
- DEPTH, 16, FIFO entries; power of two, >= 2; AW = log2(DEPTH)
- STAMPW, 16, cycle-stamp width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- arm  in  1  single-cycle pulse: start a capture session
- stop  in  1  single-cycle pulse: end the capture session
- wb_regwrite  in  1  write-back event strobe
- wb_regdata  in  32  write-back data
- mem_memwrite  in  1  store event strobe
- mem_memdata  in  32  store data
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head entry
- out_data  out  32  head entry data
- out_kind  out  1  0 = write-back event, 1 = store event
- out_stamp  out  STAMPW  head entry cycle stamp
- level  out  AW+1  entries held, 0..DEPTH
- state  out  2  00 IDLE, 01 ARMED, 10 CAPTURE, 11 HALTED
- overflow  out  1  sticky: an event was dropped this session
- dropped  out  16  dropped-event count, saturating at 16'hFFFF

## Operation
- IDLE: no capture. arm -> ARMED and clears overflow, dropped, and the stamp counter. FIFO contents are kept. arm is ignored in all other states.
- ARMED: the stamp counter holds at 0 until the first event, then the FIFO captures that event with stamp 0 and the block moves to CAPTURE.
- CAPTURE: every event is captured. The stamp counter increments every cycle and saturates at all-ones.
- stop in ARMED or CAPTURE -> HALTED. An event in the same cycle as stop is still captured.
- HALTED: no capture. Moves to IDLE in the cycle after level reaches 0.
- Simultaneous wb and mem events in one cycle produce two pushes in that cycle. The wb entry is written first (older instruction), then the mem entry, and both carry the same stamp.
- Free space is computed from the registered level. A pop in the same cycle does not free a slot for that cycle's pushes.
- If one slot is free and two events arrive, wb is captured and mem is dropped. If no slot is free, all events are dropped.
- Each drop sets overflow and increments dropped by 1 (by 2 if both are lost).
- Pointers wrap modulo DEPTH. level = pushes − pops, never exceeds DEPTH.

## Timing
- Reset values: state IDLE, level 0, out_valid 0, out_data 0, out_kind 0, out_stamp 0, overflow 0, dropped 0, pointers 0.
- Reset is asynchronous. Asserting it mid-session clears the FIFO and drops out_valid without waiting for a clock edge.
- Latency: an event sampled at edge N into an empty FIFO is on out_* after edge N, valid during cycle N+1.
- Output is show-ahead: out_data, out_kind and out_stamp are the head entry whenever out_valid = 1.
- Output is stable: out_* are held until accepted. A pop occurs at an edge where out_valid && out_ready.
- level, overflow and dropped update on the same edge as the push or pop that changes them.
- A push and a pop on the same edge leave level unchanged.

## Configuration
- WB_TRACE_STAMP_EN defined: stamp counter and the per-entry STAMPW field are present, behaving as described above.
- WB_TRACE_STAMP_EN undefined: counter and storage are removed and out_stamp is tied to 0. All other behaviour is unchanged.

## Test plan
- Reset, arm, then wb events with data 0x11, 0x22 at cycles 3 and 5 after arm, out_ready = 1 -> entries (0x11, kind 0, stamp 0) then (0x22, kind 0, stamp 2), each on the cycle after its event.
- Same-cycle wb 0xAAAA0000 and mem 0x0000BBBB -> two entries in order wb then mem, equal stamps, level goes 0->2 in one edge.
- DEPTH = 16, out_ready = 0, 18 single events -> level 16, overflow 1, dropped 2. Draining yields the first 16 in order.
- Fill to 15, then dual event with a simultaneous pop -> wb captured, mem dropped, level stays 15, dropped 1.
- stop with 3 entries held -> state HALTED, no further capture. After 3 pops, state IDLE next cycle. arm while HALTED is ignored.
- rst_n low mid-capture with level 5 -> out_valid 0 and level 0 asynchronously, state IDLE. Without WB_TRACE_STAMP_EN, out_stamp is always 0.

Source files
------------

// File: rtl/wb_trace_buf.sv
// Trace capture FIFO for CPU write-back and store events, drained through a valid/ready stream.
// Define WB_TRACE_STAMP_EN to keep the per-entry cycle stamp; otherwise out_stamp is tied to 0.
module wb_trace_buf #(
    parameter int  DEPTH  = 16,
    parameter int  STAMPW = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              stop,
    input  logic              wb_regwrite,
    input  logic [31:0]       wb_regdata,
    input  logic              mem_memwrite,
    input  logic [31:0]       mem_memdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_kind,
    output logic [STAMPW-1:0] out_stamp,
    output logic [AW:0]       level,
    output logic [1:0]        state,
    output logic              overflow,
    output logic [15:0]       dropped
);
    // state   | meaning
    // IDLE    | no capture, FIFO contents kept
    // ARMED   | waiting for first event, stamp held at 0
    // CAPTURE | every event captured, stamp running
    // HALTED  | no capture, returns to IDLE once drained
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_ARMED = 2'b01, S_CAPTURE = 2'b10, S_HALTED = 2'b11} state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t          st, st_nx;
    logic [AW-1:0]   wr_ptr, rd_ptr, mem_idx;
    logic [AW:0]     lvl, free, lvl_nx;
    logic            cap, wb_ev, mem_ev, wb_push, mem_push, pop;
    logic [1:0]      push_cnt, n_drop;
    logic [16:0]     drop_sum;
    logic [15:0]     drop_nx;

    logic [31:0]     data_mem [DEPTH];
    logic            kind_mem [DEPTH];

    always_comb begin
        st_nx = st;
        case (st)
            S_IDLE:    if (arm) st_nx = S_ARMED;
            S_ARMED:   if (stop) st_nx = S_HALTED;
                       else if (wb_regwrite || mem_memwrite) st_nx = S_CAPTURE;
            S_CAPTURE: if (stop) st_nx = S_HALTED;
            S_HALTED:  if (lvl == '0) st_nx = S_IDLE;
            default:   st_nx = S_IDLE;
        endcase
    end

    // Space is judged on the registered level; a same-cycle pop does not help this cycle's pushes.
    always_comb begin
        cap      = (st == S_ARMED) || (st == S_CAPTURE);
        wb_ev    = cap && wb_regwrite;
        mem_ev   = cap && mem_memwrite;
        free     = FULL - lvl;
        wb_push  = wb_ev && (free != '0);
        mem_push = mem_ev && (wb_push ? (free >= (AW+1)'(2)) : (free != '0));
        push_cnt = {1'b0, wb_push} + {1'b0, mem_push};
        n_drop   = {1'b0, wb_ev && !wb_push} + {1'b0, mem_ev && !mem_push};
        pop      = out_valid && out_ready;
        lvl_nx   = lvl + (AW+1)'(push_cnt) - (AW+1)'(pop);
        mem_idx  = wr_ptr + AW'(wb_push);
        drop_sum = {1'b0, dropped} + 17'(n_drop);
        drop_nx  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            lvl      <= '0;
            overflow <= 1'b0;
            dropped  <= '0;
        end else begin
            st     <= st_nx;
            wr_ptr <= wr_ptr + AW'(push_cnt);
            rd_ptr <= rd_ptr + AW'(pop);
            lvl    <= lvl_nx;
            if (st == S_IDLE && arm) begin
                overflow <= 1'b0;
                dropped  <= '0;
            end else if (n_drop != 2'd0) begin
                overflow <= 1'b1;
                dropped  <= drop_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wb_push) begin
            data_mem[wr_ptr] <= wb_regdata;
            kind_mem[wr_ptr] <= 1'b0;
        end
        if (mem_push) begin
            data_mem[mem_idx] <= mem_memdata;
            kind_mem[mem_idx] <= 1'b1;
        end
    end

`ifdef WB_TRACE_STAMP_EN
    logic [STAMPW-1:0] stamp_q;
    logic [STAMPW-1:0] stamp_mem [DEPTH];

    // The first event in ARMED takes stamp 0 and starts the count on that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stamp_q <= '0;
        end else if (st == S_IDLE && arm) begin
            stamp_q <= '0;
        end else if ((st == S_CAPTURE || (st == S_ARMED && (wb_ev || mem_ev))) && stamp_q != '1) begin
            stamp_q <= stamp_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wb_push)  stamp_mem[wr_ptr]  <= stamp_q;
        if (mem_push) stamp_mem[mem_idx] <= stamp_q;
    end

    assign out_stamp = out_valid ? stamp_mem[rd_ptr] : '0;
`else
    assign out_stamp = '0;
`endif

    assign out_valid = (lvl != '0);
    assign out_data  = out_valid ? data_mem[rd_ptr] : '0;
    assign out_kind  = out_valid ? kind_mem[rd_ptr] : 1'b0;
    assign level     = lvl;
    assign state     = st;
endmodule
